issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/scoreboard_pkg.sv | 21 ++
 rtl/sb_slot.sv | 87 ++++++++
 rtl/issue_scoreboard.sv | 194 +++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and defaults for the issue scoreboard.
package scoreboard_pkg;

    localparam int unsigned DEFAULT_DEPTH = 16;
    localparam int unsigned DEFAULT_XLEN  = 32;
    localparam int unsigned DEFAULT_REG_W = 5;

    // Slot tag width for a given number of slots (DEPTH is a power of two).
    function automatic int unsigned tag_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Per-slot status record; the payload fields live alongside it in sb_slot.
    typedef struct packed {
        logic valid;
        logic issued;
        logic done;
        logic mem;
    } slot_flags_t;

endpackage

// File: rtl/sb_slot.sv
// One scoreboard slot: status flags plus the captured instruction payload.
module sb_slot
    import scoreboard_pkg::*;
#(
    parameter int unsigned XLEN  = DEFAULT_XLEN,
    parameter int unsigned REG_W = DEFAULT_REG_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             write_i,
    input  logic             issue_i,
    input  logic             complete_i,
    input  logic             squash_i,
    input  logic             free_i,
    input  logic             mem_i,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    output slot_flags_t      flags_o,
    output logic [XLEN-1:0]  instr_o,
    output logic [XLEN-1:0]  pc_o,
    output logic [REG_W-1:0] rd_o,
    output logic [REG_W-1:0] rs1_o,
    output logic [REG_W-1:0] rs2_o
);

    slot_flags_t      flags_q, flags_d;
    logic [XLEN-1:0]  instr_q, pc_q;
    logic [REG_W-1:0] rd_q, rs1_q, rs2_q;

    // Flag next-state: a new write wins, then squash/free, then issue/complete.
    always_comb begin
        flags_d = flags_q;
        if (write_i) begin
            flags_d.valid  = 1'b1;
            flags_d.issued = 1'b0;
            flags_d.done   = 1'b0;
            flags_d.mem    = mem_i;
        end else if (squash_i || free_i) begin
            flags_d = '0;
        end else if (flags_q.valid) begin
            if (issue_i) begin
                flags_d.issued = 1'b1;
            end
            // Completion only counts for an entry that was actually issued.
            if (complete_i && flags_q.issued) begin
                flags_d.done = 1'b1;
            end
        end
    end

    // Flag register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Payload register, captured on write only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= '0;
            pc_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
        end else if (write_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            rd_q    <= rd_i;
            rs1_q   <= rs1_i;
            rs2_q   <= rs2_i;
        end
    end

    assign flags_o = flags_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign rd_o    = rd_q;
    assign rs1_o   = rs1_q;
    assign rs2_o   = rs2_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Circular-buffer issue scoreboard with RAW/WAW hazard tracking, in-order
// memory issue, oldest-first selection, flush and in-order retirement.
module issue_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned XLEN  = DEFAULT_XLEN,
    parameter int unsigned REG_W = DEFAULT_REG_W,
    localparam int unsigned TAG_W = tag_width(DEPTH),
    localparam int unsigned CNT_W = TAG_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [XLEN-1:0]  push_instr_i,
    input  logic [XLEN-1:0]  push_pc_i,
    input  logic [REG_W-1:0] push_rd_i,
    input  logic [REG_W-1:0] push_rs1_i,
    input  logic [REG_W-1:0] push_rs2_i,
    input  logic             push_mem_i,
    output logic [TAG_W-1:0] push_tag_o,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output logic [TAG_W-1:0] issue_tag_o,
    output logic [XLEN-1:0]  issue_instr_o,
    output logic [XLEN-1:0]  issue_pc_o,
    input  logic             complete_valid_i,
    input  logic [TAG_W-1:0] complete_tag_i,
    input  logic             flush_valid_i,
    input  logic [TAG_W-1:0] flush_tag_i,
    output logic             retire_valid_o,
    output logic [TAG_W-1:0] retire_tag_o,
    output logic [XLEN-1:0]  retire_pc_o,
    output logic [CNT_W-1:0] count_o,
    output logic             is_full_o,
    output logic             is_empty_o
);

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    slot_flags_t      slot_flags [DEPTH];
    logic [XLEN-1:0]  slot_instr [DEPTH];
    logic [XLEN-1:0]  slot_pc    [DEPTH];
    logic [REG_W-1:0] slot_rd    [DEPTH];
    logic [REG_W-1:0] slot_rs1   [DEPTH];
    logic [REG_W-1:0] slot_rs2   [DEPTH];
    logic [TAG_W-1:0] age        [DEPTH];

    logic [DEPTH-1:0] blocked, ready;
    logic [DEPTH-1:0] slot_write, slot_issue, slot_complete, slot_squash, slot_free;
    logic             sel_found;
    logic [TAG_W-1:0] sel_tag, scan_idx;
    logic             push_fire, issue_fire, retire_fire, flush_hit;
    logic [TAG_W-1:0] age_ft;

    assign is_full_o    = (count_q == CNT_W'(DEPTH));
    assign is_empty_o   = (count_q == '0);
    assign push_ready_o = !is_full_o && !flush_valid_i;
    assign push_tag_o   = tail_q;
    assign count_o      = count_q;

    assign push_fire   = push_valid_i && push_ready_o;
    assign issue_fire  = issue_valid_o && issue_ready_i;
    assign retire_fire = slot_flags[head_q].valid && slot_flags[head_q].done;
    // A flush naming an empty slot is ignored entirely.
    assign flush_hit   = flush_valid_i && slot_flags[flush_tag_i].valid;
    assign age_ft      = age[flush_tag_i];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        // Age 0 is the oldest entry (head); larger means younger.
        assign age[i]           = TAG_W'(i) - head_q;
        assign slot_write[i]    = push_fire && (tail_q == TAG_W'(i));
        assign slot_issue[i]    = issue_fire && (sel_tag == TAG_W'(i));
        assign slot_squash[i]   = flush_hit && (age[i] > age_ft);
        assign slot_complete[i] = complete_valid_i && (complete_tag_i == TAG_W'(i))
                                  && !slot_squash[i];
        assign slot_free[i]     = retire_fire && (head_q == TAG_W'(i));

        sb_slot #(
            .XLEN  (XLEN),
            .REG_W (REG_W)
        ) u_slot (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .write_i    (slot_write[i]),
            .issue_i    (slot_issue[i]),
            .complete_i (slot_complete[i]),
            .squash_i   (slot_squash[i]),
            .free_i     (slot_free[i]),
            .mem_i      (push_mem_i),
            .instr_i    (push_instr_i),
            .pc_i       (push_pc_i),
            .rd_i       (push_rd_i),
            .rs1_i      (push_rs1_i),
            .rs2_i      (push_rs2_i),
            .flags_o    (slot_flags[i]),
            .instr_o    (slot_instr[i]),
            .pc_o       (slot_pc[i]),
            .rd_o       (slot_rd[i]),
            .rs1_o      (slot_rs1[i]),
            .rs2_o      (slot_rs2[i])
        );
    end

    // Readiness: check every older in-flight entry for register and memory-order hazards.
    always_comb begin
        blocked = '0;
        ready   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (slot_flags[j].valid && (age[j] < age[i])) begin
                    if (!slot_flags[j].done && (slot_rd[j] != '0) &&
                        ((slot_rd[j] == slot_rs1[i]) || (slot_rd[j] == slot_rs2[i]) ||
                         (slot_rd[j] == slot_rd[i]))) begin
                        blocked[i] = 1'b1;
                    end
                    if (slot_flags[i].mem && slot_flags[j].mem && !slot_flags[j].issued) begin
                        blocked[i] = 1'b1;
                    end
                end
            end
            ready[i] = slot_flags[i].valid && !slot_flags[i].issued && !blocked[i];
        end
    end

    // Oldest-first pick: scan in age order starting at head.
    always_comb begin
        sel_found = 1'b0;
        sel_tag   = '0;
        scan_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + TAG_W'(k);
            if (!sel_found && ready[scan_idx]) begin
                sel_found = 1'b1;
                sel_tag   = scan_idx;
            end
        end
    end

    // Issue and retire outputs; data fields read as zero when not valid.
    always_comb begin
        issue_valid_o  = sel_found && !flush_valid_i;
        issue_tag_o    = '0;
        issue_instr_o  = '0;
        issue_pc_o     = '0;
        retire_valid_o = retire_fire;
        retire_tag_o   = '0;
        retire_pc_o    = '0;
        if (issue_valid_o) begin
            issue_tag_o   = sel_tag;
            issue_instr_o = slot_instr[sel_tag];
            issue_pc_o    = slot_pc[sel_tag];
        end
        if (retire_fire) begin
            retire_tag_o = head_q;
            retire_pc_o  = slot_pc[head_q];
        end
    end

    // Pointer and occupancy next-state; a flush truncates the buffer after flush_tag.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_hit) begin
            tail_d  = flush_tag_i + TAG_W'(1);
            count_d = CNT_W'(age_ft) + CNT_W'(1);
        end else if (push_fire) begin
            tail_d  = tail_q + TAG_W'(1);
            count_d = count_q + CNT_W'(1);
        end
        if (retire_fire) begin
            head_d  = head_q + TAG_W'(1);
            count_d = count_d - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: queue-based reference model plus directed scenarios
// and a randomized phase.
module tb_issue_scoreboard;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             push_valid, push_ready, push_mem;
    logic [XLEN-1:0]  push_instr, push_pc;
    logic [REG_W-1:0] push_rd, push_rs1, push_rs2;
    logic [TAG_W-1:0] push_tag;
    logic             issue_valid, issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic [XLEN-1:0]  issue_instr, issue_pc;
    logic             complete_valid;
    logic [TAG_W-1:0] complete_tag;
    logic             flush_valid;
    logic [TAG_W-1:0] flush_tag;
    logic             retire_valid;
    logic [TAG_W-1:0] retire_tag;
    logic [XLEN-1:0]  retire_pc;
    logic [CNT_W-1:0] count;
    logic             is_full, is_empty;

    issue_scoreboard #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .REG_W (REG_W)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .push_valid_i     (push_valid),
        .push_ready_o     (push_ready),
        .push_instr_i     (push_instr),
        .push_pc_i        (push_pc),
        .push_rd_i        (push_rd),
        .push_rs1_i       (push_rs1),
        .push_rs2_i       (push_rs2),
        .push_mem_i       (push_mem),
        .push_tag_o       (push_tag),
        .issue_valid_o    (issue_valid),
        .issue_ready_i    (issue_ready),
        .issue_tag_o      (issue_tag),
        .issue_instr_o    (issue_instr),
        .issue_pc_o       (issue_pc),
        .complete_valid_i (complete_valid),
        .complete_tag_i   (complete_tag),
        .flush_valid_i    (flush_valid),
        .flush_tag_i      (flush_tag),
        .retire_valid_o   (retire_valid),
        .retire_tag_o     (retire_tag),
        .retire_pc_o      (retire_pc),
        .count_o          (count),
        .is_full_o        (is_full),
        .is_empty_o       (is_empty)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: age-ordered queue of live entries ----------------
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic             mem;
        logic             issued;
        logic             done;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;
    int   exp_sel;
    bit   exp_issue_valid, exp_retire_valid, exp_push_ready;

    int n_checks = 0;
    int n_errors = 0;

    logic [TAG_W-1:0] ret_log[$];
    logic [TAG_W-1:0] iss_log[$];
    int               cand[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs from the model state and current flush input.
    function automatic void m_eval();
        bit blk;
        exp_sel = -1;
        for (int k = 0; k < q.size(); k++) begin
            if (!q[k].issued && exp_sel < 0) begin
                blk = 0;
                for (int j = 0; j < k; j++) begin
                    if (!q[j].done && q[j].rd != 0 &&
                        (q[j].rd == q[k].rs1 || q[j].rd == q[k].rs2 || q[j].rd == q[k].rd))
                        blk = 1;
                    if (q[k].mem && q[j].mem && !q[j].issued) blk = 1;
                end
                if (!blk) exp_sel = k;
            end
        end
        exp_issue_valid  = (exp_sel >= 0) && !flush_valid;
        exp_retire_valid = (q.size() > 0) && q[0].done;
        exp_push_ready   = (q.size() < DEPTH) && !flush_valid;
    endfunction

    // Model state update on each rising edge.
    always @(posedge clk) begin
        int   c_idx;
        int   f_idx;
        ent_t e;
        if (rst) begin
            q.delete();
            m_tail = 0;
        end else begin
            m_eval();
            c_idx = -1;
            f_idx = -1;
            for (int k = 0; k < q.size(); k++) begin
                if (complete_valid && q[k].tag == complete_tag && q[k].issued) c_idx = k;
                if (flush_valid && q[k].tag == flush_tag) f_idx = k;
            end
            if (exp_issue_valid && issue_ready) q[exp_sel].issued = 1'b1;
            if (c_idx >= 0) q[c_idx].done = 1'b1;
            if (f_idx >= 0) begin
                while (q.size() > f_idx + 1) void'(q.pop_back());
                m_tail = (int'(flush_tag) + 1) % DEPTH;
            end else if (push_valid && exp_push_ready) begin
                e.tag    = TAG_W'(m_tail);
                e.instr  = push_instr;
                e.pc     = push_pc;
                e.rd     = push_rd;
                e.rs1    = push_rs1;
                e.rs2    = push_rs2;
                e.mem    = push_mem;
                e.issued = 1'b0;
                e.done   = 1'b0;
                q.push_back(e);
                m_tail = (m_tail + 1) % DEPTH;
            end
            if (exp_retire_valid) void'(q.pop_front());
        end
    end

    // Compare DUT against model every cycle out of reset; log observed issues/retires.
    always @(negedge clk) begin
        if (!rst) begin
            m_eval();
            check("push_ready", push_ready, exp_push_ready);
            check("push_tag", push_tag, m_tail);
            check("count", count, q.size());
            check("is_full", is_full, q.size() == DEPTH);
            check("is_empty", is_empty, q.size() == 0);
            check("issue_valid", issue_valid, exp_issue_valid);
            check("retire_valid", retire_valid, exp_retire_valid);
            if (exp_issue_valid) begin
                check("issue_tag", issue_tag, q[exp_sel].tag);
                check("issue_instr", issue_instr, q[exp_sel].instr);
                check("issue_pc", issue_pc, q[exp_sel].pc);
            end
            if (exp_retire_valid) begin
                check("retire_tag", retire_tag, q[0].tag);
                check("retire_pc", retire_pc, q[0].pc);
            end
            if (retire_valid) ret_log.push_back(retire_tag);
            if (issue_valid && issue_ready) iss_log.push_back(issue_tag);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic idle();
        push_valid     = 1'b0;
        push_instr     = '0;
        push_pc        = '0;
        push_rd        = '0;
        push_rs1       = '0;
        push_rs2       = '0;
        push_mem       = 1'b0;
        issue_ready    = 1'b0;
        complete_valid = 1'b0;
        complete_tag   = '0;
        flush_valid    = 1'b0;
        flush_tag      = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic push(input int rd, input int rs1, input int rs2, input bit mem);
        push_valid = 1'b1;
        push_rd    = REG_W'(rd);
        push_rs1   = REG_W'(rs1);
        push_rs2   = REG_W'(rs2);
        push_mem   = mem;
        push_instr = $urandom;
        push_pc    = $urandom;
        cycle();
        push_valid = 1'b0;
    endtask

    // Issue and complete everything in flight, bounded by a cycle budget.
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            issue_ready    = 1'b1;
            complete_valid = 1'b0;
            for (int k = 0; k < q.size(); k++) begin
                if (q[k].issued && !q[k].done && !complete_valid) begin
                    complete_valid = 1'b1;
                    complete_tag   = q[k].tag;
                end
            end
            cycle();
            n++;
        end
        idle();
        look();
        check("drain_empty", is_empty, 1);
    endtask

    initial begin
        logic [63:0] v;
        rst = 1'b1;
        do_reset();
        look();
        // Reset values
        check("rst_push_ready", push_ready, 1);
        check("rst_push_tag", push_tag, 0);
        check("rst_is_empty", is_empty, 1);
        check("rst_is_full", is_full, 0);
        check("rst_count", count, 0);
        check("rst_issue_valid", issue_valid, 0);
        check("rst_retire_valid", retire_valid, 0);
        check("rst_issue_instr", issue_instr, 0);
        check("rst_retire_pc", retire_pc, 0);

        // RAW: B waits for A's completion, then issues the cycle after.
        push(3, 0, 0, 0);
        push(4, 3, 0, 0);
        look();
        check("raw_first_valid", issue_valid, 1);
        check("raw_first_tag", issue_tag, 0);
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        look();
        check("raw_blocked", issue_valid, 0);
        complete_valid = 1'b1;
        complete_tag   = 0;
        cycle();
        complete_valid = 1'b0;
        look();
        check("raw_after_valid", issue_valid, 1);
        check("raw_after_tag", issue_tag, 1);
        check("raw_retire_valid", retire_valid, 1);
        check("raw_retire_tag", retire_tag, 0);
        drain();

        // Full buffer; retire from full does not admit a same-cycle push.
        do_reset();
        push_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push_instr = i;
            push_pc    = 32'h1000 + 4 * i;
            cycle();
        end
        look();
        check("full_is_full", is_full, 1);
        check("full_count", count, 16);
        check("full_push_ready", push_ready, 0);
        issue_ready = 1'b1;
        cycle();
        issue_ready    = 1'b0;
        complete_valid = 1'b1;
        complete_tag   = 0;
        cycle();
        complete_valid = 1'b0;
        look();
        check("full_retire_valid", retire_valid, 1);
        check("full_retire_pc", retire_pc, 32'h1000);
        check("full_ready_during_retire", push_ready, 0);
        cycle();
        push_valid = 1'b0;
        look();
        check("full_ready_after_retire", push_ready, 1);
        check("full_count_after", count, 15);
        drain();

        // Flush younger than tag 2.
        do_reset();
        for (int i = 0; i < 6; i++) push(0, 0, 0, 0);
        look();
        check("flush_pre_count", count, 6);
        iss_log.delete();
        ret_log.delete();
        flush_valid = 1'b1;
        flush_tag   = 2;
        #1;
        check("flush_issue_blocked", issue_valid, 0);
        check("flush_push_blocked", push_ready, 0);
        cycle();
        flush_valid = 1'b0;
        look();
        check("flush_count", count, 3);
        check("flush_push_tag", push_tag, 3);
        drain();
        check("flush_retire_n", ret_log.size(), 3);
        check("flush_issue_n", iss_log.size(), 3);
        for (int k = 0; k < 3; k++) begin
            v = (k < ret_log.size()) ? 64'(ret_log[k]) : '1;
            check("flush_retire_tag", v, k);
        end

        // Memory ordering: the second mem op may not pass a blocked older one.
        do_reset();
        push(7, 0, 0, 0);
        push(0, 7, 0, 1);
        push(0, 0, 0, 1);
        look();
        check("mem_first_tag", issue_tag, 0);
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        look();
        check("mem_none_ready", issue_valid, 0);
        complete_valid = 1'b1;
        complete_tag   = 0;
        cycle();
        complete_valid = 1'b0;
        look();
        check("mem_older_tag", issue_tag, 1);
        issue_ready = 1'b1;
        cycle();
        issue_ready = 1'b0;
        look();
        check("mem_younger_valid", issue_valid, 1);
        check("mem_younger_tag", issue_tag, 2);
        drain();

        // Pointer wrap over 20 push/retire pairs.
        do_reset();
        ret_log.delete();
        for (int r = 0; r < 20; r++) begin
            push(0, 0, 0, 0);
            drain();
        end
        check("wrap_push_tag", push_tag, 4);
        check("wrap_retire_n", ret_log.size(), 20);
        for (int k = 0; k < 20; k++) begin
            v = (k < ret_log.size()) ? 64'(ret_log[k]) : '1;
            check("wrap_retire_tag", v, k % 16);
        end

        // Reset with 7 entries in flight and a retire pending.
        do_reset();
        for (int i = 0; i < 7; i++) push(0, 0, 0, 0);
        issue_ready = 1'b1;
        cycle();
        issue_ready    = 1'b0;
        complete_valid = 1'b1;
        complete_tag   = 0;
        cycle();
        complete_valid = 1'b0;
        look();
        check("rst7_pending_retire", retire_valid, 1);
        ret_log.delete();
        rst = 1'b1;
        #2;
        check("rst7_count", count, 0);
        check("rst7_empty", is_empty, 1);
        check("rst7_retire", retire_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        look();
        check("rst7_count_after", count, 0);
        check("rst7_no_retire_log", ret_log.size(), 0);

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 2500; c++) begin
            push_valid  = ($urandom_range(0, 99) < 55);
            push_rd     = REG_W'($urandom_range(0, 3));
            push_rs1    = REG_W'($urandom_range(0, 3));
            push_rs2    = REG_W'($urandom_range(0, 3));
            push_mem    = ($urandom_range(0, 3) == 0);
            push_instr  = $urandom;
            push_pc     = $urandom;
            issue_ready = ($urandom_range(0, 99) < 70);
            cand.delete();
            for (int k = 0; k < q.size(); k++)
                if (q[k].issued && !q[k].done) cand.push_back(k);
            complete_valid = 1'b0;
            complete_tag   = '0;
            if (cand.size() > 0 && $urandom_range(0, 99) < 60) begin
                complete_valid = 1'b1;
                complete_tag   = q[cand[$urandom_range(0, cand.size() - 1)]].tag;
            end else if ($urandom_range(0, 99) < 8) begin
                complete_valid = 1'b1;
                complete_tag   = TAG_W'($urandom_range(0, DEPTH - 1));
            end
            flush_valid = 1'b0;
            flush_tag   = '0;
            if ($urandom_range(0, 99) < 4) begin
                flush_valid = 1'b1;
                if (q.size() > 0 && $urandom_range(0, 3) != 0)
                    flush_tag = q[$urandom_range(0, q.size() - 1)].tag;
                else
                    flush_tag = TAG_W'($urandom_range(0, DEPTH - 1));
            end
            cycle();
        end
        idle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
